// File: rtl/seq_prime_detector_if.sv
// Request/result bundle for the sequential prime detector.
// The master drives start/number; the slave returns busy/done/is_prime/factor.
interface seq_prime_detector_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] number;
    logic             busy;
    logic             done;
    logic             is_prime;
    logic [WIDTH-1:0] factor;

    modport master (
        output start, number,
        input  busy, done, is_prime, factor
    );

    modport slave (
        input  start, number,
        output busy, done, is_prime, factor
    );
endinterface

// File: rtl/seq_prime_detector.sv
// Iterative trial-division primality checker: one candidate divisor per clock,
// reporting is_prime and the smallest prime factor through a start/busy/done handshake.
module seq_prime_detector #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_prime_detector_if.slave  bus
);
    localparam int DW = WIDTH + 1;
    localparam int PW = 2 * DW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [DW-1:0]    d_q, d_d;
    logic             is_prime_q, is_prime_d;
    logic [WIDTH-1:0] factor_q, factor_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [PW-1:0]    sq;
    logic [DW-1:0]    divisor;
    logic [DW-1:0]    rem;

    // Squared candidate is kept wide so the d*d > n test never truncates.
    assign sq      = PW'(d_q) * PW'(d_q);
    // d is zero only outside CHECK; substituting 1 keeps the divider defined.
    assign divisor = (d_q == '0) ? DW'(1) : d_q;
    assign rem     = {1'b0, n_q} % divisor;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        d_d        = d_q;
        is_prime_d = is_prime_q;
        factor_d   = factor_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    n_d        = bus.number;
                    d_d        = DW'(2);
                    is_prime_d = 1'b0;
                    factor_d   = '0;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (n_q < WIDTH'(2)) begin
                    is_prime_d = 1'b0;
                    factor_d   = '0;
                    state_d    = S_DONE;
                end else if (sq > PW'(n_q)) begin
                    is_prime_d = 1'b1;
                    factor_d   = '0;
                    state_d    = S_DONE;
                end else if (rem == '0) begin
                    // d*d <= n here, so d fits in WIDTH bits.
                    is_prime_d = 1'b0;
                    factor_d   = d_q[WIDTH-1:0];
                    state_d    = S_DONE;
                end else if (d_q == DW'(2)) begin
                    d_d = DW'(3);
                end else begin
                    d_d = d_q + DW'(2);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            d_q        <= '0;
            is_prime_q <= 1'b0;
            factor_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            d_q        <= d_d;
            is_prime_q <= is_prime_d;
            factor_q   <= factor_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.is_prime = is_prime_q;
    assign bus.factor   = factor_q;
endmodule
